// File: rtl/cmov_commit_if.sv
// cmov_commit_if: EX-stage inputs, hazard controls and pipeline outputs of cmov_commit_pipe (master drives EX/hazard side, slave is the pipe; CMOV_STATS_EN adds counter outputs)
interface cmov_commit_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_reg_write;
  logic              in_is_cmov;
  logic              in_movz;
  logic [REG_AW-1:0] in_rd;
  logic [DATA_W-1:0] in_rs_val;
  logic [DATA_W-1:0] in_rt_val;
  logic [DATA_W-1:0] in_result;
  logic              stall;
  logic              flush;
  logic              mem_we;
  logic [REG_AW-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
`ifdef CMOV_STATS_EN
  logic [31:0]       cmov_taken_cnt;
  logic [31:0]       cmov_squash_cnt;
  modport master (
    output in_valid, in_reg_write, in_is_cmov, in_movz, in_rd, in_rs_val, in_rt_val, in_result, stall, flush,
    input  mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data, cmov_taken_cnt, cmov_squash_cnt
  );
  modport slave (
    input  in_valid, in_reg_write, in_is_cmov, in_movz, in_rd, in_rs_val, in_rt_val, in_result, stall, flush,
    output mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data, cmov_taken_cnt, cmov_squash_cnt
  );
`else
  modport master (
    output in_valid, in_reg_write, in_is_cmov, in_movz, in_rd, in_rs_val, in_rt_val, in_result, stall, flush,
    input  mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data
  );
  modport slave (
    input  in_valid, in_reg_write, in_is_cmov, in_movz, in_rd, in_rs_val, in_rt_val, in_result, stall, flush,
    output mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data
  );
`endif
endinterface

// File: rtl/cmov_commit_pipe.sv
// cmov_commit_pipe: resolves MOVZ/MOVN, carries result through EX/MEM and MEM/WB (ports: Clk, Rst, bus slave with EX inputs, stall/flush, mem_* taps, wb_* write port; CMOV_STATS_EN adds taken/squash counters)
module cmov_commit_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic         Clk,
  input logic         Rst,
  cmov_commit_if.slave bus
);
  logic              cond;
  logic              eff_we;
  logic [DATA_W-1:0] eff_data;
  always_comb begin
    cond     = (bus.in_rt_val == '0) ~^ bus.in_movz;
    eff_we   = bus.in_valid & bus.in_reg_write & (bus.in_is_cmov ? cond : 1'b1) & (bus.in_rd != '0);
    eff_data = bus.in_is_cmov ? bus.in_rs_val : bus.in_result;
  end
  always_ff @(posedge Clk) begin
    if (Rst || bus.flush) begin
      bus.mem_we   <= 1'b0;
      bus.mem_rd   <= '0;
      bus.mem_data <= '0;
    end else if (!bus.stall) begin
      bus.mem_we   <= eff_we;
      bus.mem_rd   <= bus.in_rd;
      bus.mem_data <= eff_data;
    end
  end
  // a stall bubbles MEM/WB but keeps its address/data so only we drops
  always_ff @(posedge Clk) begin
    if (Rst) begin
      bus.wb_we   <= 1'b0;
      bus.wb_rd   <= '0;
      bus.wb_data <= '0;
    end else if (bus.stall) begin
      bus.wb_we   <= 1'b0;
    end else begin
      bus.wb_we   <= bus.mem_we;
      bus.wb_rd   <= bus.mem_rd;
      bus.wb_data <= bus.mem_data;
    end
  end
`ifdef CMOV_STATS_EN
  logic [31:0] taken_cnt;
  logic [31:0] squash_cnt;
  logic        cmov_cap;
  always_comb cmov_cap = bus.in_valid & bus.in_reg_write & bus.in_is_cmov & ~bus.stall & ~bus.flush;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      taken_cnt  <= '0;
      squash_cnt <= '0;
    end else if (cmov_cap) begin
      taken_cnt  <= taken_cnt + {31'd0, cond};
      squash_cnt <= squash_cnt + {31'd0, ~cond};
    end
  end
  assign bus.cmov_taken_cnt  = taken_cnt;
  assign bus.cmov_squash_cnt = squash_cnt;
`endif
endmodule

// File: doc/cmov_commit_pipe.md
Name: cmov_commit_pipe

Overview:
- Consumer side of the conditional-move decision.
- Takes EX-stage MOVZ/MOVN and ordinary ALU results, resolves the move condition, and carries the result through EX/MEM and MEM/WB pipeline registers.
- Drives the register-file write port, plus forwarding taps for the hazard/forwarding unit.
- Supports stall and flush from the hazard unit.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  synchronous reset, active-high.
- in_valid  input  1  EX stage holds a real instruction.
- in_reg_write  input  1  instruction writes a register.
- in_is_cmov  input  1  instruction is MOVZ or MOVN.
- in_movz  input  1  1 = MOVZ, 0 = MOVN; ignored unless in_is_cmov.
- in_rd  input  REG_AW  destination register.
- in_rs_val  input  DATA_W  rs operand; the move source.
- in_rt_val  input  DATA_W  rt operand; the move condition.
- in_result  input  DATA_W  ALU result for non-cmov instructions.
- stall  input  1  hold EX/MEM contents; inject bubble into MEM/WB.
- flush  input  1  replace EX/MEM capture with a bubble.
- mem_we  output  1  EX/MEM forwarding tap: effective write.
- mem_rd  output  REG_AW  EX/MEM destination.
- mem_data  output  DATA_W  EX/MEM data.
- wb_we  output  1  register-file write enable.
- wb_rd  output  REG_AW  register-file write address.
- wb_data  output  DATA_W  register-file write data.

Behaviour:
- Condition: cond = (in_rt_val == 0) XNOR in_movz.
  - MOVZ writes when rt == 0.
  - MOVN writes when rt != 0.
- Effective write: eff_we = in_valid & in_reg_write & (in_is_cmov ? cond : 1) & (in_rd != 0).
  - A register-0 destination never writes.
- Data select: eff_data = in_is_cmov ? in_rs_val : in_result.
- EX/MEM register update each rising Clk, in priority order:
  1. Rst: mem_we = 0, mem_rd = 0, mem_data = 0.
  2. flush: mem_we = 0; rd and data are don't-care, driven 0.
  3. stall: hold all EX/MEM fields.
  4. else: capture eff_we, in_rd, eff_data.
- MEM/WB register update each rising Clk:
  - Rst: all outputs 0.
  - stall: wb_we = 0 (bubble); wb_rd and wb_data hold.
  - else: copy mem_we, mem_rd, mem_data.
- Latency: EX inputs appear on mem_* after 1 cycle and on wb_* after 2 cycles (no stall).
- Flush and stall in the same cycle: flush wins. EX/MEM becomes a bubble; MEM/WB still receives a bubble.
- A suppressed cmov (condition false) flows as a bubble with we = 0. It must never produce a forwarding match.
- Reset mid-stream: any in-flight write is discarded; no wb_we pulse after reset deasserts until new valid input arrives.
- Outputs are registered only; no combinational input-to-output path.

Optional Feature:
- Macro CMOV_STATS_EN.
- When defined, adds outputs cmov_taken_cnt and cmov_squash_cnt, each 32 bits.
  - Counters increment on each EX/MEM capture (not stalled, not flushed) of a valid cmov with in_reg_write.
  - Taken increments when cond = 1; squash increments when cond = 0. An rd = 0 cmov counts by cond only.
  - Counters wrap modulo 2^32 and clear on Rst.
- When undefined: no counters and no ports; the datapath is identical.

Test Plan:
- MOVZ, rd=5, rt=0, rs=0xDEADBEEF -> mem_we=1 at cycle+1; wb_we=1, wb_rd=5, wb_data=0xDEADBEEF at cycle+2.
- MOVN, rd=7, rt=0, rs=0x1234 -> mem_we=0, wb_we=0. With CMOV_STATS_EN: squash count 1, taken count 0.
- ALU op, rd=3, result=0x55, then stall for 2 cycles -> mem_* holds 0x55; wb_we=0 during the stall; a single wb_we=1 pulse with wb_data=0x55 after release.
- Valid write to rd=9 with flush and stall asserted together -> mem_we=0 next cycle; no wb_we pulse for rd=9.
- Back-to-back MOVN, rd=0, rt=1, then ALU op rd=4 with Rst on the second cycle -> wb_we never 1; all outputs 0 the cycle after Rst.
- Counter wrap: preload taken count to 0xFFFFFFFF via force, issue a taken MOVZ -> count reads 0.
